// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with a per-transfer ack timeout.
// The owner keeps the bus until it drops cyc; a stalled strobe is errored and blocked.
module wb_rr_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_data,
    input  logic [3:0]  m0_sel,
    input  logic        m0_cyc,
    input  logic        m0_stb,
    input  logic        m0_we,
    output logic [31:0] m0_data_read,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_data,
    input  logic [3:0]  m1_sel,
    input  logic        m1_cyc,
    input  logic        m1_stb,
    input  logic        m1_we,
    output logic [31:0] m1_data_read,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] wb_addr,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic [31:0] wb_data_read,
    input  logic        wb_ack,
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_next;
    logic       last;
    logic [7:0] cnt;
    logic       stb_block;
    logic       own_stb;
    logic       timeout_hit;
    logic       state_change;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0_cyc && m1_cyc) state_next = last ? GRANT0 : GRANT1;
                else if (m0_cyc)      state_next = GRANT0;
                else if (m1_cyc)      state_next = GRANT1;
            end
            GRANT0: if (!m0_cyc) state_next = m1_cyc ? GRANT1 : IDLE;
            GRANT1: if (!m1_cyc) state_next = m0_cyc ? GRANT0 : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        own_stb = 1'b0;
        case (state)
            GRANT0:  own_stb = m0_stb;
            GRANT1:  own_stb = m1_stb;
            default: own_stb = 1'b0;
        endcase
    end

    assign state_change = (state_next != state);
    // A same-cycle ack beats the timeout, so wb_ack suppresses the hit.
    assign timeout_hit  = own_stb && !stb_block && !wb_ack && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            cnt       <= '0;
            stb_block <= 1'b0;
        end else begin
            state <= state_next;
            if (state != IDLE && state_change)
                last <= (state == GRANT1);

            if (state_change || wb_ack || !own_stb || stb_block || timeout_hit)
                cnt <= '0;
            else
                cnt <= cnt + 8'd1;

            if (state_change)     stb_block <= 1'b0;
            else if (timeout_hit) stb_block <= 1'b1;
            else if (!own_stb)    stb_block <= 1'b0;
        end
    end

    always_comb begin
        grant        = 2'b00;
        wb_addr      = '0;
        wb_data      = '0;
        wb_sel       = '0;
        wb_cyc       = 1'b0;
        wb_stb       = 1'b0;
        wb_we        = 1'b0;
        m0_data_read = '0;
        m0_ack       = 1'b0;
        m0_err       = 1'b0;
        m1_data_read = '0;
        m1_ack       = 1'b0;
        m1_err       = 1'b0;
        case (state)
            GRANT0: begin
                grant        = 2'b01;
                wb_addr      = m0_addr;
                wb_data      = m0_data;
                wb_sel       = m0_sel;
                wb_cyc       = m0_cyc;
                wb_stb       = m0_stb && !stb_block;
                wb_we        = m0_we;
                m0_data_read = wb_data_read;
                m0_ack       = wb_ack && !stb_block;
                m0_err       = timeout_hit;
            end
            GRANT1: begin
                grant        = 2'b10;
                wb_addr      = m1_addr;
                wb_data      = m1_data;
                wb_sel       = m1_sel;
                wb_cyc       = m1_cyc;
                wb_stb       = m1_stb && !stb_block;
                wb_we        = m1_we;
                m1_data_read = wb_data_read;
                m1_ack       = wb_ack && !stb_block;
                m1_err       = timeout_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: arbitration order, muxing, timeout and reset.
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr, m0_data, m1_addr, m1_data;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_data_read, m1_data_read;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] wb_addr, wb_data, wb_data_read;
    logic [3:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    wb_rr_arbiter #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m0_data(m0_data), .m0_sel(m0_sel), .m0_cyc(m0_cyc),
        .m0_stb(m0_stb), .m0_we(m0_we), .m0_data_read(m0_data_read),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_addr(m1_addr), .m1_data(m1_data), .m1_sel(m1_sel), .m1_cyc(m1_cyc),
        .m1_stb(m1_stb), .m1_we(m1_we), .m1_data_read(m1_data_read),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_sel(wb_sel), .wb_cyc(wb_cyc),
        .wb_stb(wb_stb), .wb_we(wb_we), .wb_data_read(wb_data_read),
        .wb_ack(wb_ack), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m0_addr = '0; m0_data = '0; m0_sel = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        m1_addr = '0; m1_data = '0; m1_sel = '0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        wb_data_read = '0; wb_ack = 0;
        #12;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_wb_stb", 32'(wb_stb), 32'd0);
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        tick();
        rst = 1'b0;

        // Simultaneous request after reset: m0 wins the first tie
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h100; m0_sel = 4'h3;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h200;
        #1;
        chk("idle_grant", 32'(grant), 32'd0);
        chk("idle_wb_cyc", 32'(wb_cyc), 32'd0);
        tick();
        chk("tie_grant", 32'(grant), 32'd1);
        chk("tie_wb_addr", wb_addr, 32'h100);
        chk("tie_wb_sel", 32'(wb_sel), 32'h3);
        chk("tie_wb_cyc", 32'(wb_cyc), 32'd1);
        wb_ack = 1; wb_data_read = 32'h12345678;
        #1;
        chk("own_ack", 32'(m0_ack), 32'd1);
        chk("own_rdata", m0_data_read, 32'h12345678);
        chk("other_ack", 32'(m1_ack), 32'd0);
        chk("other_rdata", m1_data_read, 32'd0);
        tick();
        wb_ack = 0;
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("handoff_grant", 32'(grant), 32'd2);
        chk("handoff_addr", wb_addr, 32'h200);

        // Alternation: each master drops cyc for one cycle after its transfer
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 0; m1_stb = 0;
        tick();
        chk("alt1_grant", 32'(grant), 32'd1);
        m1_cyc = 1; m1_stb = 1;
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("alt2_grant", 32'(grant), 32'd2);
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 0; m1_stb = 0;
        tick();
        chk("alt3_grant", 32'(grant), 32'd1);
        m1_cyc = 1; m1_stb = 1;
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("alt4_grant", 32'(grant), 32'd2);

        // m1 write mux, and no ack leaks to m0
        m1_addr = 32'h0000_0010; m1_we = 1; m1_data = 32'hDEADBEEF; m1_sel = 4'hF;
        #1;
        chk("m1_wb_addr", wb_addr, 32'h10);
        chk("m1_wb_data", wb_data, 32'hDEADBEEF);
        chk("m1_wb_we", 32'(wb_we), 32'd1);
        chk("m1_wb_sel", 32'(wb_sel), 32'hF);
        wb_ack = 1;
        #1;
        chk("m1_ack", 32'(m1_ack), 32'd1);
        chk("m0_no_ack", 32'(m0_ack), 32'd0);
        tick();
        wb_ack = 0;

        // Drop everything -> idle; m0 owns next, then a tie after m0 goes to m1
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
        tick();
        chk("idle_again", 32'(grant), 32'd0);
        chk("idle_addr", wb_addr, 32'd0);
        chk("idle_we", 32'(wb_we), 32'd0);
        m0_cyc = 1; m0_stb = 1;
        tick();
        chk("m0_only", 32'(grant), 32'd1);
        m0_cyc = 0; m0_stb = 0;
        tick();
        chk("idle_last0", 32'(grant), 32'd0);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        tick();
        chk("tie_last0", 32'(grant), 32'd2);
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        chk("idle_pre_to", 32'(grant), 32'd0);

        // Timeout: slave never acks, err on 15th strobe cycle
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int i = 1; i <= 14; i++) begin
            chk($sformatf("to_noerr_%0d", i), 32'(m0_err), 32'd0);
            if (i == 1) chk("to_stb_on", 32'(wb_stb), 32'd1);
            tick();
        end
        chk("to_err", 32'(m0_err), 32'd1);
        chk("to_stb_still", 32'(wb_stb), 32'd1);
        chk("to_m1_err", 32'(m1_err), 32'd0);
        tick();
        chk("to_stb_blocked", 32'(wb_stb), 32'd0);
        chk("to_err_pulse", 32'(m0_err), 32'd0);
        chk("to_cyc_kept", 32'(wb_cyc), 32'd1);
        wb_ack = 1;
        #1;
        chk("blocked_ack", 32'(m0_ack), 32'd0);
        wb_ack = 0;
        tick();
        chk("still_blocked", 32'(wb_stb), 32'd0);
        m0_stb = 0;
        tick();
        m0_stb = 1;
        #1;
        chk("unblocked", 32'(wb_stb), 32'd1);

        // Ack on the 15th cycle wins over the timeout
        for (int i = 1; i <= 14; i++) tick();
        wb_ack = 1;
        #1;
        chk("race_ack", 32'(m0_ack), 32'd1);
        chk("race_err", 32'(m0_err), 32'd0);
        tick();
        wb_ack = 0;
        #1;
        chk("race_stb", 32'(wb_stb), 32'd1);
        chk("race_err_after", 32'(m0_err), 32'd0);

        // Asynchronous reset mid-transfer, stray ack in idle, then re-arbitration
        #2;
        rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("arst_wb_stb", 32'(wb_stb), 32'd0);
        tick();
        rst = 1'b0;
        wb_ack = 1;
        #1;
        chk("stray_m0_ack", 32'(m0_ack), 32'd0);
        chk("stray_m1_ack", 32'(m1_ack), 32'd0);
        wb_ack = 0;
        tick();
        chk("resume_grant", 32'(grant), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
